// File: rtl/cdma_cfg_master.sv
// AXI-Lite master that programs a CDMA core (source, destination, length)
// and optionally polls its status register until the core reports idle.
module cdma_cfg_master #(
    parameter int unsigned        ADDR_W   = 10,
    parameter int unsigned        DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  SA_OFS   = ADDR_W'(10'h18),
    parameter logic [ADDR_W-1:0]  DA_OFS   = ADDR_W'(10'h20),
    parameter logic [ADDR_W-1:0]  BTT_OFS  = ADDR_W'(10'h28),
    parameter logic [ADDR_W-1:0]  SR_OFS   = ADDR_W'(10'h04),
    parameter bit                 POLL_EN  = 1'b1,
    parameter int unsigned        IDLE_BIT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dma_en,
    input  logic [DATA_W-1:0]   read_addr,
    input  logic [DATA_W-1:0]   write_addr,
    input  logic [DATA_W-1:0]   byte_len,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready
);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_WRESP, S_RADDR, S_RDATA, S_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [DATA_W-1:0]   da_q, da_d, btt_q, btt_d;
    logic                busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                arvalid_q, arvalid_d, bready_q, bready_d, rready_q, rready_d;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        da_d      = da_q;
        btt_d     = btt_q;
        error_d   = error_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        bready_d  = bready_q;
        rready_d  = rready_q;
        case (state_q)
            S_IDLE: begin
                if (dma_en) begin
                    da_d    = write_addr;
                    btt_d   = byte_len;
                    idx_d   = 2'd0;
                    error_d = 1'b0;
                    if (byte_len == '0) begin
                        error_d = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        // The source address goes straight into the first write beat.
                        state_d   = S_WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = SA_OFS;
                        wdata_d   = read_addr;
                    end
                end
            end
            S_WRITE: begin
                if (awvalid_q && awready) awvalid_d = 1'b0;
                if (wvalid_q && wready)   wvalid_d  = 1'b0;
                if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
                    state_d  = S_WRESP;
                    bready_d = 1'b1;
                end
            end
            S_WRESP: begin
                if (bvalid) begin
                    bready_d = 1'b0;
                    if (bresp != 2'b00) begin
                        error_d = 1'b1;
                        state_d = S_FINISH;
                    end else if (idx_q != 2'd2) begin
                        idx_d     = idx_q + 2'd1;
                        state_d   = S_WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = (idx_q == 2'd0) ? DA_OFS : BTT_OFS;
                        wdata_d   = (idx_q == 2'd0) ? da_q : btt_q;
                    end else if (POLL_EN) begin
                        state_d   = S_RADDR;
                        arvalid_d = 1'b1;
                        araddr_d  = SR_OFS;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_RADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RDATA;
                end
            end
            S_RDATA: begin
                if (rvalid) begin
                    rready_d = 1'b0;
                    if (rresp != 2'b00) begin
                        error_d = 1'b1;
                        state_d = S_FINISH;
                    end else if (rdata[IDLE_BIT]) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d   = S_RADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= 2'd0;
            da_q      <= '0;
            btt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            da_q      <= da_d;
            btt_q     <= btt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;
    assign awaddr  = awaddr_q;
    assign awvalid = awvalid_q;
    assign wdata   = wdata_q;
    assign wstrb   = '1;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;
    assign araddr  = araddr_q;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;

endmodule

// File: tb/tb_cdma_cfg_master.sv
// Directed bench for cdma_cfg_master: one write-only instance and one polling
// instance, each behind a small always-ready AXI-Lite slave model.
module tb_cdma_cfg_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        dma_en0 = 1'b0, dma_en1 = 1'b0;
    logic [31:0] read_addr = '0, write_addr = '0, byte_len = '0;
    logic        awready = 1'b1, wready = 1'b1, bvalid = 1'b1, arready = 1'b1, rvalid = 1'b1;
    logic [1:0]  rresp = 2'b00;

    logic        busy0, done0, error0, awvalid0, wvalid0, bready0, arvalid0, rready0;
    logic [9:0]  awaddr0, araddr0;
    logic [31:0] wdata0, rdata0;
    logic [3:0]  wstrb0;
    logic [1:0]  bresp0;
    logic        busy1, done1, error1, awvalid1, wvalid1, bready1, arvalid1, rready1;
    logic [9:0]  awaddr1, araddr1;
    logic [31:0] wdata1, rdata1;
    logic [3:0]  wstrb1;
    logic [1:0]  bresp1;

    int vec = 0, mis = 0;
    int aw_cnt0 = 0, b_cnt0 = 0, aw_cnt1 = 0, ar_cnt1 = 0, ar_ok1 = 0;
    logic [9:0]  aw_log0 [64];
    logic [31:0] w_log0  [64];
    int err_at = -1;
    int ar_base = 0;

    assign bresp0 = (b_cnt0 == err_at) ? 2'b10 : 2'b00;
    assign bresp1 = 2'b00;
    assign rdata0 = 32'h0;
    assign rdata1 = ((ar_cnt1 - ar_base) >= 3) ? 32'h2 : 32'h0;

    cdma_cfg_master #(.POLL_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .dma_en(dma_en0),
        .read_addr(read_addr), .write_addr(write_addr), .byte_len(byte_len),
        .busy(busy0), .done(done0), .error(error0),
        .awaddr(awaddr0), .awvalid(awvalid0), .awready(awready),
        .wdata(wdata0), .wstrb(wstrb0), .wvalid(wvalid0), .wready(wready),
        .bresp(bresp0), .bvalid(bvalid), .bready(bready0),
        .araddr(araddr0), .arvalid(arvalid0), .arready(arready),
        .rdata(rdata0), .rresp(rresp), .rvalid(rvalid), .rready(rready0)
    );

    cdma_cfg_master #(.POLL_EN(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .dma_en(dma_en1),
        .read_addr(read_addr), .write_addr(write_addr), .byte_len(byte_len),
        .busy(busy1), .done(done1), .error(error1),
        .awaddr(awaddr1), .awvalid(awvalid1), .awready(awready),
        .wdata(wdata1), .wstrb(wstrb1), .wvalid(wvalid1), .wready(wready),
        .bresp(bresp1), .bvalid(bvalid), .bready(bready1),
        .araddr(araddr1), .arvalid(arvalid1), .arready(arready),
        .rdata(rdata1), .rresp(rresp), .rvalid(rvalid), .rready(rready1)
    );

    // Handshake logger; counters only grow so each test works from a snapshot.
    always @(posedge clk) begin
        if (awvalid0 && awready) begin
            aw_log0[aw_cnt0[5:0]] <= awaddr0;
            aw_cnt0 <= aw_cnt0 + 1;
        end
        if (wvalid0 && wready) w_log0[aw_cnt0[5:0]] <= wdata0;
        if (bvalid && bready0) b_cnt0 <= b_cnt0 + 1;
        if (awvalid1 && awready) aw_cnt1 <= aw_cnt1 + 1;
        if (arvalid1 && arready) begin
            ar_cnt1 <= ar_cnt1 + 1;
            if (araddr1 == 10'h004) ar_ok1 <= ar_ok1 + 1;
        end
    end

    // Returns with the bench sampling in cycle 1 (the cycle after dma_en was seen).
    task automatic start(input int which, input logic [31:0] a, input logic [31:0] b, input logic [31:0] l);
        @(negedge clk);
        read_addr = a; write_addr = b; byte_len = l;
        if (which == 0) dma_en0 = 1'b1; else dma_en1 = 1'b1;
        @(posedge clk); #1;
        dma_en0 = 1'b0; dma_en1 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int budget, output int cyc);
        cyc = -1;
        for (int c = 1; c <= budget; c++) begin
            if ((which == 0 && done0 === 1'b1) || (which == 1 && done1 === 1'b1)) begin
                cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        #1;
        vec++; if ({busy0, done0, error0, awvalid0, wvalid0, arvalid0, bready0, rready0} !== 8'h00) begin
            mis++; $display("FAIL reset_ctl0 got %b want 00000000", {busy0, done0, error0, awvalid0, wvalid0, arvalid0, bready0, rready0}); end
        vec++; if ({awaddr0, araddr0, wdata0} !== 52'h0) begin
            mis++; $display("FAIL reset_data0 got %h/%h/%h want 0", awaddr0, araddr0, wdata0); end
        vec++; if ({busy1, done1, error1, awvalid1, wvalid1, arvalid1, bready1, rready1} !== 8'h00) begin
            mis++; $display("FAIL reset_ctl1 got %b want 00000000", {busy1, done1, error1, awvalid1, wvalid1, arvalid1, bready1, rready1}); end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_basic;
        int base, cyc;
        base = aw_cnt0;
        start(0, 32'h1000, 32'h2000, 32'd20);
        wait_done(0, 50, cyc);
        vec++; if (cyc != 7) begin mis++; $display("FAIL basic_latency got %0d want 7", cyc); end
        vec++; if (error0 !== 1'b0) begin mis++; $display("FAIL basic_error got %b want 0", error0); end
        vec++; if (aw_cnt0 - base != 3) begin mis++; $display("FAIL basic_nwrites got %0d want 3", aw_cnt0 - base); end
        vec++; if (aw_log0[base] !== 10'h18 || w_log0[base] !== 32'h1000) begin
            mis++; $display("FAIL basic_w0 got %h/%h want 018/00001000", aw_log0[base], w_log0[base]); end
        vec++; if (aw_log0[base+1] !== 10'h20 || w_log0[base+1] !== 32'h2000) begin
            mis++; $display("FAIL basic_w1 got %h/%h want 020/00002000", aw_log0[base+1], w_log0[base+1]); end
        vec++; if (aw_log0[base+2] !== 10'h28 || w_log0[base+2] !== 32'd20) begin
            mis++; $display("FAIL basic_w2 got %h/%h want 028/00000014", aw_log0[base+2], w_log0[base+2]); end
        vec++; if (wstrb0 !== 4'hF) begin mis++; $display("FAIL basic_wstrb got %h want f", wstrb0); end
        @(posedge clk); #1;
        vec++; if (done0 !== 1'b0 || busy0 !== 1'b0) begin
            mis++; $display("FAIL basic_pulse done=%b busy=%b want 0/0", done0, busy0); end
        $display("test_basic done latency=%0d", cyc);
    endtask

    task automatic test_aw_delay;
        int base, bbase, cyc;
        base = aw_cnt0; bbase = b_cnt0;
        awready = 1'b0;
        start(0, 32'hA0, 32'hB0, 32'd4);
        vec++; if (awvalid0 !== 1'b1 || wvalid0 !== 1'b1) begin
            mis++; $display("FAIL awd_c1 aw=%b w=%b want 1/1", awvalid0, wvalid0); end
        @(posedge clk); #1;
        vec++; if (awvalid0 !== 1'b1 || wvalid0 !== 1'b0 || awaddr0 !== 10'h18) begin
            mis++; $display("FAIL awd_c2 aw=%b w=%b addr=%h want 1/0/018", awvalid0, wvalid0, awaddr0); end
        @(posedge clk); #1;
        vec++; if (awvalid0 !== 1'b1 || awaddr0 !== 10'h18) begin
            mis++; $display("FAIL awd_c3 aw=%b addr=%h want 1/018", awvalid0, awaddr0); end
        @(posedge clk); #1;
        vec++; if (awvalid0 !== 1'b1 || awaddr0 !== 10'h18 || bready0 !== 1'b0) begin
            mis++; $display("FAIL awd_c4 aw=%b addr=%h bready=%b want 1/018/0", awvalid0, awaddr0, bready0); end
        awready = 1'b1;
        @(posedge clk); #1;
        vec++; if (awvalid0 !== 1'b0 || bready0 !== 1'b1) begin
            mis++; $display("FAIL awd_c5 aw=%b bready=%b want 0/1", awvalid0, bready0); end
        wait_done(0, 50, cyc);
        vec++; if (cyc == -1 || error0 !== 1'b0) begin mis++; $display("FAIL awd_done cyc=%0d err=%b want done/0", cyc, error0); end
        vec++; if (aw_cnt0 - base != 3 || b_cnt0 - bbase != 3) begin
            mis++; $display("FAIL awd_counts aw=%0d b=%0d want 3/3", aw_cnt0 - base, b_cnt0 - bbase); end
        vec++; if (w_log0[base] !== 32'hA0) begin mis++; $display("FAIL awd_data got %h want 000000a0", w_log0[base]); end
        @(posedge clk); #1;
        $display("test_aw_delay done");
    endtask

    task automatic test_bresp_err;
        int base, cyc;
        base = aw_cnt0;
        err_at = b_cnt0 + 1;
        start(0, 32'h11, 32'h22, 32'd8);
        wait_done(0, 50, cyc);
        err_at = -1;
        vec++; if (cyc == -1) begin mis++; $display("FAIL berr_done got timeout want pulse"); end
        vec++; if (error0 !== 1'b1) begin mis++; $display("FAIL berr_error got %b want 1", error0); end
        vec++; if (aw_cnt0 - base != 2) begin mis++; $display("FAIL berr_nwrites got %0d want 2", aw_cnt0 - base); end
        @(posedge clk); #1;
        vec++; if (error0 !== 1'b1 || busy0 !== 1'b0) begin
            mis++; $display("FAIL berr_sticky err=%b busy=%b want 1/0", error0, busy0); end
        $display("test_bresp_err done");
    endtask

    task automatic test_busy_ignore;
        int base, cyc;
        base = aw_cnt0;
        start(0, 32'h3000, 32'h4000, 32'd64);
        @(negedge clk);
        read_addr = 32'h5555; write_addr = 32'h6666; byte_len = 32'd7; dma_en0 = 1'b1;
        @(posedge clk); #1;
        dma_en0 = 1'b0;
        wait_done(0, 50, cyc);
        vec++; if (error0 !== 1'b0) begin mis++; $display("FAIL busy_errclr got %b want 0", error0); end
        vec++; if (aw_cnt0 - base != 3) begin mis++; $display("FAIL busy_nwrites got %0d want 3", aw_cnt0 - base); end
        vec++; if (w_log0[base] !== 32'h3000 || w_log0[base+1] !== 32'h4000 || w_log0[base+2] !== 32'd64) begin
            mis++; $display("FAIL busy_operands got %h/%h/%h want 3000/4000/40", w_log0[base], w_log0[base+1], w_log0[base+2]); end
        @(posedge clk); #1;
        vec++; if (busy0 !== 1'b0) begin mis++; $display("FAIL busy_norestart got %b want 0", busy0); end
        $display("test_busy_ignore done");
    endtask

    task automatic test_byte_len_zero;
        int base, cyc;
        base = aw_cnt0;
        start(0, 32'h1, 32'h2, 32'd0);
        vec++; if (awvalid0 !== 1'b0) begin mis++; $display("FAIL zero_awvalid got %b want 0", awvalid0); end
        wait_done(0, 5, cyc);
        vec++; if (cyc != 1) begin mis++; $display("FAIL zero_latency got %0d want 1", cyc); end
        vec++; if (error0 !== 1'b1) begin mis++; $display("FAIL zero_error got %b want 1", error0); end
        @(posedge clk); #1;
        vec++; if (aw_cnt0 != base || busy0 !== 1'b0) begin
            mis++; $display("FAIL zero_noaxi writes=%0d busy=%b want 0/0", aw_cnt0 - base, busy0); end
        $display("test_byte_len_zero done");
    endtask

    task automatic test_poll;
        int awb, okb, cyc;
        ar_base = ar_cnt1; awb = aw_cnt1; okb = ar_ok1;
        start(1, 32'h100, 32'h200, 32'd16);
        wait_done(1, 60, cyc);
        vec++; if (cyc != 13) begin mis++; $display("FAIL poll_latency got %0d want 13", cyc); end
        vec++; if (ar_cnt1 - ar_base != 3 || ar_ok1 - okb != 3) begin
            mis++; $display("FAIL poll_reads got %0d (at 0x04: %0d) want 3/3", ar_cnt1 - ar_base, ar_ok1 - okb); end
        vec++; if (error1 !== 1'b0 || aw_cnt1 - awb != 3) begin
            mis++; $display("FAIL poll_status err=%b writes=%0d want 0/3", error1, aw_cnt1 - awb); end
        @(posedge clk); #1;
        vec++; if (busy1 !== 1'b0 || rready1 !== 1'b0) begin
            mis++; $display("FAIL poll_idle busy=%b rready=%b want 0/0", busy1, rready1); end
        $display("test_poll done latency=%0d", cyc);
    endtask

    task automatic test_reset_mid;
        int base, cyc;
        base = aw_cnt0;
        awready = 1'b0;
        start(0, 32'h7000, 32'h8000, 32'd12);
        vec++; if (awvalid0 !== 1'b1) begin mis++; $display("FAIL rmid_pre got %b want 1", awvalid0); end
        #2 rst_n = 1'b0;
        #1;
        vec++; if ({awvalid0, wvalid0, arvalid0, busy0, bready0} !== 5'b0 || awaddr0 !== 10'h0) begin
            mis++; $display("FAIL rmid_async got %b addr=%h want 00000/000", {awvalid0, wvalid0, arvalid0, busy0, bready0}, awaddr0); end
        @(negedge clk) rst_n = 1'b1;
        awready = 1'b1;
        repeat (2) @(posedge clk); #1;
        vec++; if (busy0 !== 1'b0 || aw_cnt0 != base) begin
            mis++; $display("FAIL rmid_idle busy=%b writes=%0d want 0/0", busy0, aw_cnt0 - base); end
        start(0, 32'h7100, 32'h8100, 32'd12);
        wait_done(0, 50, cyc);
        vec++; if (cyc != 7 || aw_log0[base] !== 10'h18 || w_log0[base] !== 32'h7100) begin
            mis++; $display("FAIL rmid_restart cyc=%0d addr=%h data=%h want 7/018/00007100", cyc, aw_log0[base], w_log0[base]); end
        @(posedge clk); #1;
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_aw_delay();
        test_bresp_err();
        test_busy_ignore();
        test_byte_len_zero();
        test_poll();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule

// File: doc/cdma_cfg_master.md
CDMA_CFG_MASTER -- requirements
Module: cdma_cfg_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, AXI-Lite address width.
REQ-002 SHALL have parameter DATA_W, default 32, AXI-Lite data width and address/length operand width.
REQ-003 SHALL have parameters SA_OFS 10'h18, DA_OFS 10'h20, BTT_OFS 10'h28, SR_OFS 10'h04: CDMA register offsets (source, destination, bytes-to-transfer, status).
REQ-004 SHALL have parameter POLL_EN, default 1: 1 = poll status until idle after the BTT write; 0 = finish after the BTT write response.
REQ-005 SHALL have parameter IDLE_BIT, default 1: status bit meaning CDMA idle.
REQ-006 SHALL have ports: clk in 1, system clock; rst_n in 1, asynchronous active-low reset.
REQ-007 SHALL have ports: dma_en in 1, start request; read_addr in DATA_W, source address; write_addr in DATA_W, destination address; byte_len in DATA_W, transfer length.
REQ-008 SHALL have ports: busy out 1, sequence active; done out 1, one-cycle completion pulse; error out 1, sticky error flag.
REQ-009 SHALL have AW channel ports: awaddr out ADDR_W; awvalid out 1; awready in 1.
REQ-010 SHALL have W channel ports: wdata out DATA_W; wstrb out DATA_W/8, all ones; wvalid out 1; wready in 1.
REQ-011 SHALL have B channel ports: bresp in 2; bvalid in 1; bready out 1.
REQ-012 SHALL have AR/R channel ports: araddr out ADDR_W; arvalid out 1; arready in 1; rdata in DATA_W; rresp in 2; rvalid in 1; rready out 1.

Function
REQ-013 SHALL implement states IDLE, WRITE, WRESP, RADDR, RDATA, FINISH.
REQ-014 IDLE: dma_en=1 SHALL latch read_addr, write_addr, byte_len, clear error, set write index to 0 and enter WRITE next cycle.
REQ-015 IDLE: dma_en=1 with byte_len=0 SHALL set error and enter FINISH without issuing any AXI transaction.
REQ-016 SHALL address writes by index: 0 -> SA_OFS / latched read_addr, 1 -> DA_OFS / latched write_addr, 2 -> BTT_OFS / latched byte_len.
REQ-017 WRITE: awvalid and wvalid SHALL assert together; each SHALL drop independently the cycle after its own handshake (valid & ready); WRESP SHALL be entered once both handshakes complete, in the same or different cycles.
REQ-018 awaddr/wdata SHALL stay stable while their valid is high; valids SHALL never drop before handshake.
REQ-019 WRESP: bready SHALL be 1; on bvalid with bresp=0, index 0/1 SHALL increment index and return to WRITE; index 2 SHALL go to RADDR if POLL_EN=1, else FINISH.
REQ-020 WRESP: bvalid with bresp!=0 SHALL set error and go to FINISH; no further writes.
REQ-021 RADDR: arvalid=1 with araddr=SR_OFS until arready, then RDATA.
REQ-022 RDATA: rready=1; on rvalid: rresp!=0 -> error, FINISH; rdata[IDLE_BIT]=1 -> FINISH; else -> RADDR (re-poll, no cap).
REQ-023 FINISH SHALL assert done for exactly one cycle, then return to IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 dma_en while busy SHALL be ignored; latched operands SHALL not change.
REQ-026 bready SHALL be 0 outside WRESP; rready 0 outside RDATA.
REQ-027 Minimum latency with all readies and responses immediate, POLL_EN=0: dma_en high at cycle 0 -> done at cycle 7.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, index 0, and busy, done, error, awvalid, wvalid, arvalid, bready, rready to 0; awaddr, araddr, wdata to 0.
REQ-029 Reset mid-transaction SHALL drop all valids without completing handshakes; the next sequence starts only on a new dma_en.

Verification
REQ-030 Readies always 1, bresp=0, POLL_EN=0, read_addr=32'h1000, write_addr=32'h2000, byte_len=20 -> writes 0x18/0x1000, 0x20/0x2000, 0x28/20 in order; done pulse cycle 7; error=0.
REQ-031 awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid holds 4 cycles with stable awaddr; single B wait per write.
REQ-032 bresp=2'b10 on second write -> error=1, done pulse, no BTT write issued.
REQ-033 POLL_EN=1, rdata bit1=0 twice then 1 -> three AR reads at 0x04, then done; error=0.
REQ-034 byte_len=0 -> no awvalid ever, error=1 and done pulse within 2 cycles.
REQ-035 rst_n low while awvalid=1 -> all valids 0 immediately; dma_en re-issued after release restarts at SA_OFS.
